mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage plus the MEM/WB pipeline register.
- Takes EX/MEM fields and issues data-memory loads/stores over a req/ready handshake, stalling upstream while memory is busy.
- Byte-lane aligns store data and sign/zero-extends load data.
- Registers ALU result, load data, PC+4, destination register and WB control into the writeback stage inputs (ALUResultW, ReadDataW, PCPlus4W, controlW).

Parameters:
XLEN, 32, datapath and address width
REGW, 5, register-index width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
validM  in  1  instruction in MEM is real (0 = bubble)
ALUResultM  in  XLEN  ALU result / effective address
WriteDataM  in  XLEN  store data (rs2)
PCPlus4M  in  XLEN  PC+4 of instruction
RdM  in  REGW  destination register
RegWriteM  in  1  writes register file
ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4
MemReadM  in  1  load
MemWriteM  in  1  store
funct3M  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  XLEN  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ready  in  1  memory accepts/completes request this cycle
dmem_rdata  in  XLEN  read word, valid when dmem_ready
stallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
ALUResultW  out  XLEN  registered
ReadDataW  out  XLEN  registered, extended load data
PCPlus4W  out  XLEN  registered
RdW  out  REGW  registered
controlW  out  3  registered {RegWrite, ResultSrc[1:0]}
misalignW  out  1  registered one-cycle misaligned-access flag

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE. dmem_req=0, stallM=0. All W outputs and misalignW = 0. Memory outputs go inactive immediately, mid-transaction included; any pending request is abandoned.
- Memory op: mem_op = validM & (MemReadM|MemWriteM).
- Misalignment: h/hu with addr[0]=1, or w with addr[1:0]!=0.
  - No request is issued.
  - MEM/WB loads with controlW RegWrite forced 0 and misalignW=1 for one cycle.
- FSM states IDLE, WAIT.
  - IDLE, aligned mem_op: dmem_req=1 combinationally, with fields from current inputs.
    - dmem_ready=1: access completes this cycle, MEM/WB loads, stay IDLE, stallM=0 (1-cycle latency).
    - dmem_ready=0: latch addr/wdata/be/we/funct3/addr[1:0], go WAIT, stallM=1.
  - WAIT: dmem_req=1 with latched fields held stable; stallM=1.
    - dmem_ready=1: MEM/WB loads (load data uses latched funct3/offset), go IDLE. stallM=0 in that cycle, so upstream advances on the same edge.
    - N wait cycles give total latency N+1.
  - IDLE, non-memory or bubble: MEM/WB loads every cycle. validM=0 loads controlW=0.
- While stallM=1 and the access is not completing, MEM/WB loads a bubble (controlW=000, misalignW=0). Data fields may hold.
- Store lanes:
  - sb: wdata = byte replicated ×4, be = 4'b0001<<addr[1:0].
  - sh: wdata = half replicated ×2, be = addr[1] ? 1100 : 0011.
  - sw: be = 1111.
  - Stores load MEM/WB with RegWrite as given (normally 0).
- Load extract: byte/half selected by addr[1:0]. b/h sign-extend, bu/hu zero-extend, w passes through.
- ReadDataW is 0 for non-load instructions.
- funct3 other than the five listed is treated as w.
- Simultaneous MemReadM and MemWriteM: store takes priority, ReadDataW=0.

Decomposition:
- Shared package: funct3 load/store constants, ResultSrc encodings (ALU/MEM/PC4), FSM state enum {IDLE, WAIT}, controlW bit positions.
- One combinational sub-module, lsu_lane_align: store replicate + be generation, load extract/extend, misalign detect. Shared by the request path and the completion path.

Test Plan:
- sw addr 0x104, data 0xDEADBEEF, dmem_ready=1 -> same cycle dmem_req=1, we=1, addr=0x104, be=1111, stallM=0; next cycle controlW=000.
- lb addr 0x203, rdata 0x80112233, 2 wait cycles -> stallM high 2 cycles, req/addr 0x200 stable; ReadDataW=0xFFFFFF80, controlW=101 on the edge after ready.
- lhu addr 0x202, rdata 0xBEEF1234, ready=1 -> ReadDataW=0x0000BEEF. Then sh addr 0x202, data 0x00005678 -> wdata=0x56785678, be=1100.
- lw addr 0x101 -> dmem_req stays 0, misalignW=1 one cycle, controlW RegWrite=0.
- Back-to-back: add (RegWrite, ALU 0x55), then lw with 1 wait, then add -> W sees add, bubble, lw, add in order, none lost or duplicated.
- rst_n low during WAIT -> dmem_req and stallM drop immediately (asynchronously), all W outputs 0. After release, the next lw issues normally.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: funct3 sizes, ResultSrc,
// FSM states and controlW bit positions.
package mem_access_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  localparam int CW_RW    = 2;
  localparam int CW_RS_HI = 1;
  localparam int CW_RS_LO = 0;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Unlisted funct3 codes fall back to a word access.
  function automatic size_t f3_size(
    input logic [2:0] f3
  );
    size_t s;
    unique case (f3)
      F3_B, F3_BU: s = SZ_B;
      F3_H, F3_HU: s = SZ_H;
      default:     s = SZ_W;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_access_stage_lsu_lane_align.sv
// Byte-lane logic: store replicate/byte enables, misalign detect,
// and load extract with sign/zero extension.
// Ports: st_* request side (funct3, offset, rs2 data -> wdata, be,
// misalign); ld_* completion side (funct3, offset, word -> data).
module lsu_lane_align
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_be,
  output logic            st_misalign,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data
);

  size_t st_sz;
  size_t ld_sz;
  logic  ld_uns;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign st_sz  = f3_size(st_funct3);
  assign ld_sz  = f3_size(ld_funct3);
  assign ld_uns = ld_funct3[2];

  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b1111;
    unique case (st_sz)
      SZ_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << st_off;
      end
      SZ_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = st_data;
        st_be    = 4'b1111;
      end
    endcase
  end

  assign st_misalign =
    ((st_sz == SZ_H) && st_off[0]) ||
    ((st_sz == SZ_W) && (st_off != 2'b00));

  always_comb begin
    ld_b = 8'h00;
    unique case (ld_off)
      2'd0: ld_b = ld_word[7:0];
      2'd1: ld_b = ld_word[15:8];
      2'd2: ld_b = ld_word[23:16];
      2'd3: ld_b = ld_word[31:24];
      default: ld_b = 8'h00;
    endcase
  end

  assign ld_h = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_data = ld_word;
    unique case (ld_sz)
      SZ_B: ld_data = ld_uns ?
        {{(XLEN-8){1'b0}}, ld_b} :
        {{(XLEN-8){ld_b[7]}}, ld_b};
      SZ_H: ld_data = ld_uns ?
        {{(XLEN-16){1'b0}}, ld_h} :
        {{(XLEN-16){ld_h[15]}}, ld_h};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage with data-memory req/ready handshake and MEM/WB register.
// Ports: EX/MEM fields in (*M), dmem_* bus, stallM upstream, *W out.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            validM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [REGW-1:0] RdM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      funct3M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stallM,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [REGW-1:0] RdW,
  output logic [2:0]      controlW,
  output logic            misalignW
);

  state_t state;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;

  logic            in_wait;
  logic            mem_op;
  logic            st_mis;
  logic            misalign;
  logic            issue;
  logic            done;
  logic            load_done;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_be;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] cur_addr;

  assign in_wait  = (state == WAIT);
  assign mem_op   = validM & (MemReadM | MemWriteM);
  assign cur_addr = {ALUResultM[XLEN-1:2], 2'b00};

  lsu_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .st_funct3  (funct3M),
    .st_off     (ALUResultM[1:0]),
    .st_data    (WriteDataM),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .st_misalign(st_mis),
    .ld_funct3  (in_wait ? f3_q : funct3M),
    .ld_off     (in_wait ? off_q : ALUResultM[1:0]),
    .ld_word    (dmem_rdata),
    .ld_data    (ld_data)
  );

  // Misalignment only matters when a new access is being considered.
  assign misalign = mem_op & st_mis & ~in_wait;
  assign issue    = ~in_wait & mem_op & ~misalign;

  // rst_n gates the bus so it drops mid-transaction without a clock.
  assign dmem_req   = rst_n & (issue | in_wait);
  assign dmem_we    = dmem_req & (in_wait ? we_q : MemWriteM);
  assign dmem_addr  = in_wait ? addr_q : cur_addr;
  assign dmem_wdata = in_wait ? wdata_q : st_wdata;
  assign dmem_be    = in_wait ? be_q : st_be;

  assign stallM    = dmem_req & ~dmem_ready;
  assign done      = dmem_req & dmem_ready;
  // Store wins when both read and write are set.
  assign load_done = done & ~(in_wait ? we_q : MemWriteM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      controlW   <= '0;
      misalignW  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue && !dmem_ready) begin
            state   <= WAIT;
            addr_q  <= cur_addr;
            wdata_q <= st_wdata;
            be_q    <= st_be;
            we_q    <= MemWriteM;
            f3_q    <= funct3M;
            off_q   <= ALUResultM[1:0];
          end
        end
        WAIT: begin
          if (dmem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (stallM) begin
        controlW  <= '0;
        misalignW <= 1'b0;
      end else begin
        ALUResultW <= ALUResultM;
        PCPlus4W   <= PCPlus4M;
        RdW        <= RdM;
        ReadDataW  <= load_done ? ld_data : '0;
        misalignW  <= misalign;
        if (validM) begin
          controlW[CW_RW] <= RegWriteM & ~misalign;
          controlW[CW_RS_HI:CW_RS_LO] <= ResultSrcM;
        end else begin
          controlW <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus
// multi-cycle sequences, MEM/WB results checked via a queue.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        validM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stallM;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RdW;
  logic [2:0]  controlW;
  logic        misalignW;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .validM    (validM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .PCPlus4M  (PCPlus4M),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .ResultSrcM(ResultSrcM),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .funct3M   (funct3M),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_be   (dmem_be),
    .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .stallM    (stallM),
    .ALUResultW(ALUResultW),
    .ReadDataW (ReadDataW),
    .PCPlus4W  (PCPlus4W),
    .RdW       (RdW),
    .controlW  (controlW),
    .misalignW (misalignW)
  );

  typedef struct {
    logic        req;
    logic        stall;
    logic        we;
    logic        chk_st;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } cexp_t;

  typedef struct {
    logic [2:0]  ctl;
    logic        mis;
    logic        chk;
    logic [31:0] rdw;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } wexp_t;

  typedef struct {
    logic        v, rd, wr, rw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] a, wd, word;
    logic        e_req;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    logic [31:0] e_rdw;
    logic [2:0]  e_ctl;
    logic        e_mis;
  } vec_t;

  wexp_t sb[$];
  vec_t  vt[$];

  localparam wexp_t BUB = '{ctl: 3'b000, mis: 1'b0, chk: 1'b0,
    rdw: 32'h0, alu: 32'h0, pc4: 32'h0, rd: 5'h0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic v, rd, wr, rw,
                        input logic [1:0] rs, input logic [2:0] f3,
                        input logic [31:0] a, wd,
                        input logic [4:0] r, input logic [31:0] pc);
    validM = v; MemReadM = rd; MemWriteM = wr;
    RegWriteM = rw; ResultSrcM = rs; funct3M = f3;
    ALUResultM = a; WriteDataM = wd; RdM = r; PCPlus4M = pc;
  endtask

  task automatic tick(input logic rdy, input logic [31:0] word,
                      input cexp_t c, input wexp_t w);
    wexp_t e;
    dmem_ready = rdy;
    dmem_rdata = word;
    sb.push_back(w);
    @(negedge clk);
    chk("req", 32'(dmem_req), 32'(c.req));
    chk("stall", 32'(stallM), 32'(c.stall));
    if (c.req) chk("addr", dmem_addr, c.addr);
    if (c.req) chk("we", 32'(dmem_we), 32'(c.we));
    if (c.chk_st) begin
      chk("wdata", dmem_wdata, c.wd);
      chk("be", 32'(dmem_be), 32'(c.be));
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_underflow: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("controlW", 32'(controlW), 32'(e.ctl));
      chk("misalignW", 32'(misalignW), 32'(e.mis));
      if (e.chk) begin
        chk("ReadDataW", ReadDataW, e.rdw);
        chk("ALUResultW", ALUResultW, e.alu);
        chk("PCPlus4W", PCPlus4W, e.pc4);
        chk("RdW", 32'(RdW), 32'(e.rd));
      end
    end
  endtask

  function automatic vec_t mv(
    input logic v, rd, wr, rw, input logic [1:0] rs,
    input logic [2:0] f3, input logic [31:0] a, wd, word,
    input logic req, input logic [31:0] e_wd, input logic [3:0] e_be,
    input logic [31:0] e_rdw, input logic [2:0] e_ctl,
    input logic e_mis);
    vec_t t;
    t.v = v; t.rd = rd; t.wr = wr; t.rw = rw; t.rs = rs; t.f3 = f3;
    t.a = a; t.wd = wd; t.word = word; t.e_req = req;
    t.e_wd = e_wd; t.e_be = e_be; t.e_rdw = e_rdw;
    t.e_ctl = e_ctl; t.e_mis = e_mis;
    return t;
  endfunction

  initial begin
    cexp_t c;
    wexp_t w;
    vec_t  t;
    logic [31:0] pc;

    set_in(0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;

    // single-cycle accesses (ready=1)
    vt.push_back(mv(1,0,1,0,2'b00,3'b010,32'h104,32'hDEADBEEF,0,
                    1,32'hDEADBEEF,4'hF,0,3'b000,0));
    vt.push_back(mv(1,1,0,1,2'b01,3'b101,32'h202,0,32'hBEEF1234,
                    1,0,0,32'h0000BEEF,3'b101,0));
    vt.push_back(mv(1,0,1,0,2'b00,3'b001,32'h202,32'h00005678,0,
                    1,32'h56785678,4'hC,0,3'b000,0));
    vt.push_back(mv(1,1,0,1,2'b01,3'b010,32'h101,0,32'h11111111,
                    0,0,0,0,3'b001,1));
    vt.push_back(mv(1,0,1,0,2'b00,3'b000,32'h103,32'h000000A5,0,
                    1,32'hA5A5A5A5,4'h8,0,3'b000,0));
    vt.push_back(mv(1,1,0,1,2'b01,3'b001,32'h200,0,32'h12348001,
                    1,0,0,32'hFFFF8001,3'b101,0));
    vt.push_back(mv(1,1,0,1,2'b01,3'b100,32'h201,0,32'h11223344,
                    1,0,0,32'h00000033,3'b101,0));
    vt.push_back(mv(1,1,0,1,2'b01,3'b000,32'h202,0,32'h007F0000,
                    1,0,0,32'h0000007F,3'b101,0));
    vt.push_back(mv(1,0,0,1,2'b00,3'b000,32'h55,0,0,
                    0,0,0,0,3'b100,0));
    vt.push_back(mv(0,1,0,1,2'b01,3'b010,32'h100,0,32'h99,
                    0,0,0,0,3'b000,0));
    vt.push_back(mv(1,1,0,1,2'b01,3'b011,32'h300,0,32'hCAFEBABE,
                    1,0,0,32'hCAFEBABE,3'b101,0));
    vt.push_back(mv(1,1,1,0,2'b00,3'b010,32'h108,32'h12345678,
                    32'h77777777,1,32'h12345678,4'hF,0,3'b000,0));
    vt.push_back(mv(1,0,1,0,2'b00,3'b001,32'h203,32'h1,0,
                    0,0,0,0,3'b000,1));
    vt.push_back(mv(1,0,0,1,2'b10,3'b000,32'h44,0,0,
                    0,0,0,0,3'b110,0));

    // reset state, with a load presented during reset
    repeat (2) @(posedge clk);
    #1;
    set_in(1, 1, 0, 1, 2'b01, 3'b010, 32'h40, 0, 5'd1, 32'h4);
    #1;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(stallM), 0);
    chk("rst_controlW", 32'(controlW), 0);
    chk("rst_ReadDataW", ReadDataW, 0);
    chk("rst_ALUResultW", ALUResultW, 0);
    chk("rst_misalignW", 32'(misalignW), 0);
    set_in(0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      t  = vt[i];
      pc = 32'h1000 + 32'(i) * 4;
      set_in(t.v, t.rd, t.wr, t.rw, t.rs, t.f3, t.a, t.wd,
             5'(i + 1), pc);
      c = '{req: t.e_req, stall: 1'b0, we: t.wr,
            chk_st: t.wr & t.e_req, addr: {t.a[31:2], 2'b00},
            wd: t.e_wd, be: t.e_be};
      w = '{ctl: t.e_ctl, mis: t.e_mis, chk: 1'b1, rdw: t.e_rdw,
            alu: t.a, pc4: pc, rd: 5'(i + 1)};
      tick(1'b1, t.word, c, w);
    end

    // lb with two wait cycles
    set_in(1, 1, 0, 1, 2'b01, 3'b000, 32'h203, 0, 5'd6, 32'h2000);
    c = '{req: 1, stall: 1, we: 0, chk_st: 0, addr: 32'h200,
          wd: 0, be: 0};
    tick(1'b0, 32'hFFFFFFFF, c, BUB);
    tick(1'b0, 32'hFFFFFFFF, c, BUB);
    c.stall = 1'b0;
    w = '{ctl: 3'b101, mis: 0, chk: 1, rdw: 32'hFFFFFF80,
          alu: 32'h203, pc4: 32'h2000, rd: 5'd6};
    tick(1'b1, 32'h80112233, c, w);

    // add, lw (1 wait), add
    set_in(1, 0, 0, 1, 2'b00, 3'b000, 32'h55, 0, 5'd3, 32'h3000);
    c = '{req: 0, stall: 0, we: 0, chk_st: 0, addr: 0, wd: 0, be: 0};
    w = '{ctl: 3'b100, mis: 0, chk: 1, rdw: 0,
          alu: 32'h55, pc4: 32'h3000, rd: 5'd3};
    tick(1'b1, 32'h0, c, w);
    set_in(1, 1, 0, 1, 2'b01, 3'b010, 32'h400, 0, 5'd4, 32'h3004);
    c = '{req: 1, stall: 1, we: 0, chk_st: 0, addr: 32'h400,
          wd: 0, be: 0};
    tick(1'b0, 32'h0, c, BUB);
    c.stall = 1'b0;
    w = '{ctl: 3'b101, mis: 0, chk: 1, rdw: 32'h13572468,
          alu: 32'h400, pc4: 32'h3004, rd: 5'd4};
    tick(1'b1, 32'h13572468, c, w);
    set_in(1, 0, 0, 1, 2'b00, 3'b000, 32'h66, 0, 5'd5, 32'h3008);
    c = '{req: 0, stall: 0, we: 0, chk_st: 0, addr: 0, wd: 0, be: 0};
    w = '{ctl: 3'b100, mis: 0, chk: 1, rdw: 0,
          alu: 32'h66, pc4: 32'h3008, rd: 5'd5};
    tick(1'b1, 32'h0, c, w);

    // async reset while waiting on memory
    set_in(1, 1, 0, 1, 2'b01, 3'b010, 32'h500, 0, 5'd8, 32'h4000);
    c = '{req: 1, stall: 1, we: 0, chk_st: 0, addr: 32'h500,
          wd: 0, be: 0};
    tick(1'b0, 32'h0, c, BUB);
    chk("wait_req", 32'(dmem_req), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_req), 0);
    chk("arst_stall", 32'(stallM), 0);
    chk("arst_ALUResultW", ALUResultW, 0);
    chk("arst_PCPlus4W", PCPlus4W, 0);
    chk("arst_RdW", 32'(RdW), 0);
    chk("arst_controlW", 32'(controlW), 0);
    set_in(0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_in(1, 1, 0, 1, 2'b01, 3'b010, 32'h508, 0, 5'd7, 32'h5000);
    c = '{req: 1, stall: 0, we: 0, chk_st: 0, addr: 32'h508,
          wd: 0, be: 0};
    w = '{ctl: 3'b101, mis: 0, chk: 1, rdw: 32'h0BADF00D,
          alu: 32'h508, pc4: 32'h5000, rd: 5'd7};
    tick(1'b1, 32'h0BADF00D, c, w);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
